mmio_ctrl: RTL

Memory-mapped I/O controller, the parametrised successor to the combinational memory mapper. It decodes CPU word accesses into the data memory, screen memory and an I/O page. Unlike the mapper, it owns the registered sound, LED and cycle-counter registers, and buffers keyboard codes in a FIFO that pops when read. It sits between the single-cycle CPU data port and the memories and peripherals in the top level.

---
 rtl/mmio_pkg.sv | 23 ++
 rtl/mmio_keyq.sv | 63 ++++++
 rtl/mmio_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the memory-mapped I/O controller.
// I/O page offsets, the region decode type and KEY register layout.
package mmio_pkg;

   localparam logic [4:0] KEY_OFS    = 5'h00;
   localparam logic [4:0] ACCEL_OFS  = 5'h04;
   localparam logic [4:0] SOUND_OFS  = 5'h08;
   localparam logic [4:0] LED_OFS    = 5'h0C;
   localparam logic [4:0] KSTAT_OFS  = 5'h10;
   localparam logic [4:0] CYCLES_OFS = 5'h14;

   localparam int IO_BYTES = 24;

   localparam int KEY_VALID_BIT = 31;

   typedef enum logic [1:0] {
      R_NONE,
      R_DMEM,
      R_SMEM,
      R_IO
   } region_e;

endpackage

// File: rtl/mmio_keyq.sv
// mmio_keyq: keyboard code FIFO with circular pointers.
// Head is visible combinationally; overflow is sticky until cleared.
module mmio_keyq #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clr_ovf,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           head,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;
   logic             ovf_set;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   // A pop frees a slot in the same cycle, so a full queue still accepts.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign ovf_set = push & full & ~do_pop;

   // Storage needs no reset: pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointer, occupancy and sticky overflow state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (ovf_set)      overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end

endmodule

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: decodes CPU word accesses into data, screen and I/O space.
// Owns sound, LED, cycle counter registers and the keyboard FIFO.
module mmio_ctrl
   import mmio_pkg::*;
#(
   parameter int                   wordsize   = 32,
   parameter logic [wordsize-1:0]  DMEM_BASE  = 32'h1001_0000,
   parameter int                   DMEM_WORDS = 1024,
   parameter logic [wordsize-1:0]  SMEM_BASE  = 32'h1002_0000,
   parameter int                   SMEM_WORDS = 1200,
   parameter logic [wordsize-1:0]  IO_BASE    = 32'h1003_0000,
   parameter int                   KEYQ_DEPTH = 8,
   parameter int                   LED_BITS   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_rd,
   input  logic                  cpu_wr,
   input  logic [wordsize-1:0]   cpu_addr,
   input  logic [wordsize-1:0]   cpu_writedata,
   output logic [wordsize-1:0]   cpu_readdata,
   output logic                  dmem_wr,
   input  logic [wordsize-1:0]   dmem_readdata,
   output logic                  smem_wr,
   input  logic [wordsize-1:0]   smem_readdata,
   input  logic                  key_valid,
   input  logic [7:0]            key_code,
   input  logic [wordsize-1:0]   accel_val,
   output logic [wordsize-1:0]   sound_period,
   output logic [LED_BITS-1:0]   lights,
   output logic                  bus_err
);

   localparam int CW = $clog2(KEYQ_DEPTH) + 1;

   localparam logic [wordsize-1:0] DMEM_SPAN = wordsize'(4 * DMEM_WORDS);
   localparam logic [wordsize-1:0] SMEM_SPAN = wordsize'(4 * SMEM_WORDS);
   localparam logic [wordsize-1:0] IO_SPAN   = wordsize'(IO_BYTES);

   logic [wordsize-1:0] dmem_ofs;
   logic [wordsize-1:0] smem_ofs;
   logic [wordsize-1:0] io_ofs;
   logic                dmem_hit;
   logic                smem_hit;
   logic                io_hit;
   logic                aligned;
   region_e             region;
   logic [4:0]          io_sel;
   logic                io_wr;
   logic                key_pop;
   logic                wr_sound;
   logic                wr_led;
   logic                wr_kstat;
   logic                wr_cycles;
   logic [7:0]          key_head;
   logic                key_empty;
   logic [CW-1:0]       key_count;
   logic                key_ovf;
   logic [wordsize-1:0] cycles;
   logic [wordsize-1:0] io_rdata;

   assign dmem_ofs = cpu_addr - DMEM_BASE;
   assign smem_ofs = cpu_addr - SMEM_BASE;
   assign io_ofs   = cpu_addr - IO_BASE;

   assign dmem_hit = (cpu_addr >= DMEM_BASE) && (dmem_ofs < DMEM_SPAN);
   assign smem_hit = (cpu_addr >= SMEM_BASE) && (smem_ofs < SMEM_SPAN);
   assign io_hit   = (cpu_addr >= IO_BASE) && (io_ofs < IO_SPAN);
   assign aligned  = (cpu_addr[1:0] == 2'b00);

   // Region decode; misaligned addresses never map anywhere.
   always_comb begin
      region = R_NONE;
      if (aligned) begin
         unique case (1'b1)
            dmem_hit: region = R_DMEM;
            smem_hit: region = R_SMEM;
            io_hit:   region = R_IO;
            default:  region = R_NONE;
         endcase
      end
   end

   assign io_sel    = io_ofs[4:0];
   assign io_wr     = cpu_wr & (region == R_IO);
   assign key_pop   = cpu_rd & (region == R_IO) & (io_sel == KEY_OFS);
   assign wr_sound  = io_wr & (io_sel == SOUND_OFS);
   assign wr_led    = io_wr & (io_sel == LED_OFS);
   assign wr_kstat  = io_wr & (io_sel == KSTAT_OFS);
   assign wr_cycles = io_wr & (io_sel == CYCLES_OFS);

   assign dmem_wr = cpu_wr & (region == R_DMEM);
   assign smem_wr = cpu_wr & (region == R_SMEM);

   mmio_keyq #(
      .DEPTH (KEYQ_DEPTH),
      .WIDTH (8)
   ) u_keyq (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (key_valid),
      .pop      (key_pop),
      .clr_ovf  (wr_kstat),
      .din      (key_code),
      .head     (key_head),
      .empty    (key_empty),
      .count    (key_count),
      .overflow (key_ovf)
   );

   // I/O page read mux; KEY reads zero when nothing is queued.
   always_comb begin
      io_rdata = '0;
      unique case (io_sel)
         KEY_OFS: begin
            if (!key_empty) begin
               io_rdata[KEY_VALID_BIT] = 1'b1;
               io_rdata[7:0]           = key_head;
            end
         end
         ACCEL_OFS:  io_rdata = accel_val;
         SOUND_OFS:  io_rdata = sound_period;
         LED_OFS:    io_rdata[LED_BITS-1:0] = lights;
         KSTAT_OFS: begin
            io_rdata[KEY_VALID_BIT] = key_ovf;
            io_rdata[CW-1:0]        = key_count;
         end
         CYCLES_OFS: io_rdata = cycles;
         default:    io_rdata = '0;
      endcase
   end

   // CPU read data mux; unmapped accesses read as zero.
   always_comb begin
      cpu_readdata = '0;
      case (region)
         R_DMEM:  cpu_readdata = dmem_readdata;
         R_SMEM:  cpu_readdata = smem_readdata;
         R_IO:    cpu_readdata = io_rdata;
         default: cpu_readdata = '0;
      endcase
   end

   // Peripheral registers, cycle counter and the bus error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sound_period <= '0;
         lights       <= '0;
         cycles       <= '0;
         bus_err      <= 1'b0;
      end else begin
         if (wr_sound) sound_period <= cpu_writedata;
         if (wr_led)   lights <= cpu_writedata[LED_BITS-1:0];
         if (wr_cycles) cycles <= cpu_writedata;
         else           cycles <= cycles + 1'b1;
         bus_err <= (cpu_rd | cpu_wr) & (region == R_NONE);
      end
   end

endmodule
